sram_mem_controller: RTL and testbench
======================================

// Module: sram_mem_controller
// PURPOSE
//  Multi-cycle controller between the MEM stage and a 16-bit external SRAM.
//  Takes the stage's 32-bit word read/write requests and performs them as two
//  16-bit SRAM accesses. Holds ready low while busy, and the pipeline freezes
//  all stage registers until ready returns high.
// PARAMETERS
//  BASE_ADDR     1024  byte address that maps to SRAM word 0
//  ACCESS_CYCLES 6     cycles from request sample to ready pulse (>=4)
// PORTS
//  clk           in    1   system clock, rising edge
//  rst           in    1   reset, asynchronous, active-low
//  rd_en         in    1   MEM-stage read request, held until ready=1
//  wr_en         in    1   MEM-stage write request, held until ready=1
//  address       in    32  byte address (ALU result), word aligned
//  write_data    in    32  store data
//  read_data     out   32  load data, valid in the cycle ready=1
//  ready         out   1   0 = stall pipeline; 1 = request complete or idle
//  SRAM_DQ       inout 16  SRAM data bus
//  SRAM_ADDR     out   18  SRAM half-word address
//  SRAM_WE_N     out   1   write enable, active-low
//  SRAM_OE_N     out   1   output enable, active-low
//  SRAM_CE_N, SRAM_UB_N, SRAM_LB_N  out 1  tied 0 (always selected)
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE, counter 0, read_data 0, WE_N=1, OE_N=1,
//    DQ high-Z, SRAM_ADDR 0. The first edge after rst rises is a normal edge.
//  - Address map: word = (address - BASE_ADDR) >> 2, truncated to 17 bits.
//    LOW half at {word,1'b0}; HIGH half at {word,1'b1}.
//  - FSM states: IDLE -> LOW -> HIGH -> WAIT -> DONE -> IDLE.
//    IDLE: ready = ~(rd_en|wr_en), combinational, so it drops in the request
//      cycle (T0). The FSM goes to LOW on the next edge if rd_en|wr_en is set.
//    LOW (T1): drive the low-half address.
//      Write: WE_N=0, DQ=write_data[15:0].
//      Read: OE_N=0; on the exit edge read_data[15:0] <= DQ.
//    HIGH (T2): same as LOW, using the high half and bits [31:16].
//    WAIT: WE_N=OE_N=1, DQ high-Z. Stays for ACCESS_CYCLES-4 cycles, counted by
//      the wait counter. If ACCESS_CYCLES=4, HIGH goes straight to DONE.
//    DONE (T = ACCESS_CYCLES-1): ready=1 for exactly one cycle, then IDLE.
//      The request is still asserted in this cycle and is ignored. The pipeline
//      advances on this edge.
//  - Default timing: ready is 0 for T0..T4 and 1 at T5.
//  - rd_en and wr_en together is illegal upstream; the controller performs a write.
//  - Request is captured at the IDLE->LOW edge (address, write_data, rd/wr).
//    Input changes mid-access are ignored.
//  - DQ is driven only in write LOW/HIGH; otherwise high-Z. There is never
//    WE_N=0 and OE_N=0 at the same time.
//  - read_data keeps its last value between accesses. It is unchanged by writes.
//  - Reset mid-access aborts immediately: outputs return to reset values and a
//    partial write may leave only the low half updated.
// STRUCTURE
//  - Shared package mips_defs: FSM state encoding (IDLE/LOW/HIGH/WAIT/DONE),
//    SRAM_BASE_ADDR default, SRAM widths (16 data, 18 address).
//  - Single module. No sub-module; the DQ tristate is one continuous assign.
//  - The bench supplies a behavioural sram_model (256K x 16, asynchronous read)
//    outside the RTL.
// TESTING
//  - Write 0xDEADBEEF @1024 -> SRAM[0]=0xBEEF, SRAM[1]=0xDEAD; ready 0 for 5
//    cycles, then 1 for 1 cycle.
//  - Read @1024 after the above -> read_data=0xDEADBEEF in the ready=1 cycle;
//    OE_N low only at T1/T2.
//  - Write 0x12345678 @1028 then read back -> SRAM_ADDR 2,3 used; readback equal.
//    SRAM[0..1] unchanged.
//  - Back-to-back: a read is held through DONE, then a new write is presented
//    next cycle -> exactly two accesses, no extra one.
//  - Reset asserted at T1 of a write -> outputs at reset values asynchronously,
//    ready=1 after release with no request pending.
//  - ACCESS_CYCLES=4 build -> ready pulses at T3; data is identical to the
//    default build.

Source files
------------

// File: rtl/mips_defs.sv
// Shared definitions for the MEM-stage SRAM controller: FSM encoding and SRAM geometry.
package mips_defs;

  // Access sequencer states: request accepted in idle, two half-word phases,
  // optional padding, then a one-cycle completion pulse.
  typedef enum logic [2:0] {
    StIdle,
    StLow,
    StHigh,
    StWait,
    StDone
  } sram_state_t;

  localparam int unsigned SRAM_BASE_ADDR = 1024;
  localparam int unsigned SRAM_DATA_W    = 16;
  localparam int unsigned SRAM_ADDR_W    = 18;

endpackage

// File: rtl/sram_mem_controller.sv
// Turns 32-bit MEM-stage loads/stores into two 16-bit accesses on an external
// asynchronous SRAM, stalling the pipeline (ready=0) until the access is done.
module sram_mem_controller
  import mips_defs::*;
#(
  parameter int unsigned BASE_ADDR     = SRAM_BASE_ADDR,
  parameter int unsigned ACCESS_CYCLES = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_OE_N,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_UB_N,
  output logic                   SRAM_LB_N
);

  // Padding cycles between the high-half phase and the completion pulse.
  localparam int unsigned WaitCycles = ACCESS_CYCLES - 4;
  localparam int unsigned WaitLast   = (WaitCycles > 0) ? WaitCycles - 1 : 0;

  sram_state_t            state_q;
  logic [7:0]             cnt_q;
  logic                   is_wr_q;
  logic [15:0]            wdata_hi_q;
  logic [15:0]            dq_out_q;
  logic                   dq_oe_q;
  logic                   we_n_q;
  logic                   oe_n_q;
  logic [SRAM_ADDR_W-1:0] sram_addr_q;
  logic [31:0]            read_data_q;
  logic [16:0]            word_addr;

  // Byte address relative to the SRAM window, in 32-bit words, kept to 17 bits.
  assign word_addr = 17'((address - 32'(BASE_ADDR)) >> 2);

  // Sequencer: captures the request on leaving idle and registers all SRAM strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      is_wr_q     <= 1'b0;
      wdata_hi_q  <= '0;
      dq_out_q    <= '0;
      dq_oe_q     <= 1'b0;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      sram_addr_q <= '0;
      read_data_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (rd_en || wr_en) begin
            state_q     <= StLow;
            // Simultaneous rd/wr resolves to a write.
            is_wr_q     <= wr_en;
            wdata_hi_q  <= write_data[31:16];
            sram_addr_q <= {word_addr, 1'b0};
            if (wr_en) begin
              we_n_q   <= 1'b0;
              dq_oe_q  <= 1'b1;
              dq_out_q <= write_data[15:0];
            end else begin
              oe_n_q <= 1'b0;
            end
          end
        end
        StLow: begin
          state_q        <= StHigh;
          sram_addr_q[0] <= 1'b1;
          if (is_wr_q) begin
            dq_out_q <= wdata_hi_q;
          end else begin
            read_data_q[15:0] <= SRAM_DQ;
          end
        end
        StHigh: begin
          we_n_q  <= 1'b1;
          oe_n_q  <= 1'b1;
          dq_oe_q <= 1'b0;
          cnt_q   <= '0;
          if (!is_wr_q) begin
            read_data_q[31:16] <= SRAM_DQ;
          end
          state_q <= (WaitCycles == 0) ? StDone : StWait;
        end
        StWait: begin
          if (cnt_q == 8'(WaitLast)) begin
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StDone: begin
          // Request is still held here by the frozen pipeline; ignore it.
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Ready drops combinationally in the request cycle so the pipeline freezes at once.
  always_comb begin
    ready = 1'b0;
    if (state_q == StIdle) begin
      ready = ~(rd_en | wr_en);
    end else if (state_q == StDone) begin
      ready = 1'b1;
    end
  end

  assign SRAM_DQ   = dq_oe_q ? dq_out_q : 'z;
  assign SRAM_ADDR = sram_addr_q;
  assign SRAM_WE_N = we_n_q;
  assign SRAM_OE_N = oe_n_q;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign read_data = read_data_q;

endmodule

// File: tb/tb_sram_mem_controller.sv
// Bench for sram_mem_controller: default (6-cycle) and 4-cycle builds, each
// with its own behavioural 256K x 16 asynchronous-read SRAM.
module tb_sram_mem_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en, wr_en, sel;
  logic [31:0] address, write_data;

  always #5 clk = ~clk;

  wire  [15:0] dq6, dq4;
  logic [17:0] a6, a4;
  logic        we6, oe6, ce6, ub6, lb6, we4, oe4, ce4, ub4, lb4;
  logic [31:0] rd6, rd4;
  logic        rdy6, rdy4;

  sram_mem_controller #(.BASE_ADDR(1024), .ACCESS_CYCLES(6)) dut6 (
    .clk(clk), .rst(rst), .rd_en(rd_en & ~sel), .wr_en(wr_en & ~sel),
    .address(address), .write_data(write_data), .read_data(rd6), .ready(rdy6),
    .SRAM_DQ(dq6), .SRAM_ADDR(a6), .SRAM_WE_N(we6), .SRAM_OE_N(oe6),
    .SRAM_CE_N(ce6), .SRAM_UB_N(ub6), .SRAM_LB_N(lb6)
  );

  sram_mem_controller #(.BASE_ADDR(1024), .ACCESS_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst), .rd_en(rd_en & sel), .wr_en(wr_en & sel),
    .address(address), .write_data(write_data), .read_data(rd4), .ready(rdy4),
    .SRAM_DQ(dq4), .SRAM_ADDR(a4), .SRAM_WE_N(we4), .SRAM_OE_N(oe4),
    .SRAM_CE_N(ce4), .SRAM_UB_N(ub4), .SRAM_LB_N(lb4)
  );

  // Behavioural SRAMs: write sampled while WE_N is low, read is asynchronous.
  logic [15:0] mem6 [0:262143];
  logic [15:0] mem4 [0:262143];
  always @(posedge clk) if (!we6) mem6[a6] <= dq6;
  always @(posedge clk) if (!we4) mem4[a4] <= dq4;
  assign dq6 = (!oe6 && we6) ? mem6[a6] : 16'hzzzz;
  assign dq4 = (!oe4 && we4) ? mem4[a4] : 16'hzzzz;

  // View of whichever build is under test.
  logic        m_ready, m_we, m_oe;
  logic [17:0] m_addr;
  logic [31:0] m_rd;
  assign m_ready = sel ? rdy4 : rdy6;
  assign m_we    = sel ? we4 : we6;
  assign m_oe    = sel ? oe4 : oe6;
  assign m_addr  = sel ? a4 : a6;
  assign m_rd    = sel ? rd4 : rd6;

  // Counts low-half strobe cycles of the default build, i.e. started accesses.
  int starts6 = 0;
  always @(negedge clk) if ((!oe6 || !we6) && !a6[0]) starts6++;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] mem_at(input logic [17:0] idx);
    return sel ? mem4[idx] : mem6[idx];
  endfunction

  // Present a request at a negedge and follow it until ready, recording strobes per cycle.
  task automatic access(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, output int lat, output logic [31:0] rdat,
                        output logic [7:0] oe_m, output logic [7:0] we_m,
                        output logic [17:0] a1, output logic [17:0] a2,
                        output logic both_low);
    @(negedge clk);
    rd_en = r; wr_en = w; address = a; write_data = d;
    lat = -1; rdat = '0; oe_m = '0; we_m = '0; a1 = '0; a2 = '0; both_low = 1'b0;
    for (int t = 0; t < 16; t++) begin
      #1;
      if (t < 8) begin
        oe_m[t] = ~m_oe;
        we_m[t] = ~m_we;
      end
      if (t == 1) a1 = m_addr;
      if (t == 2) a2 = m_addr;
      if (!m_oe && !m_we) both_low = 1'b1;
      if (m_ready) begin
        lat  = t;
        rdat = m_rd;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    rd_en = 1'b0; wr_en = 1'b0;
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [17:0] exp_lo;
  } vec_t;

  // Full access with all per-transaction checks; lat_exp is the ready cycle.
  task automatic run_vec(input vec_t v, input int lat_exp, input string tag);
    int          lat;
    logic [31:0] rdat;
    logic [7:0]  oe_m, we_m;
    logic [17:0] a1, a2;
    logic        both;
    access(v.rd, v.wr, v.addr, v.wdata, lat, rdat, oe_m, we_m, a1, a2, both);
    check({tag, " latency"}, 32'(lat), 32'(lat_exp));
    check({tag, " read_data"}, rdat, v.exp_rdata);
    check({tag, " addr T1"}, 32'(a1), 32'(v.exp_lo));
    check({tag, " addr T2"}, 32'(a2), 32'(v.exp_lo | 18'd1));
    check({tag, " we/oe overlap"}, 32'(both), 32'd0);
    if (v.wr) begin
      check({tag, " WE_N low cycles"}, 32'(we_m), 32'h06);
      check({tag, " OE_N low cycles"}, 32'(oe_m), 32'h00);
      check({tag, " sram low half"}, 32'(mem_at(v.exp_lo)), 32'(v.wdata[15:0]));
      check({tag, " sram high half"}, 32'(mem_at(v.exp_lo | 18'd1)), 32'(v.wdata[31:16]));
    end else begin
      check({tag, " OE_N low cycles"}, 32'(oe_m), 32'h06);
      check({tag, " WE_N low cycles"}, 32'(we_m), 32'h00);
    end
  endtask

  vec_t vecs [8];

  initial begin
    int s0;
    vecs[0] = '{1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 32'h00000000, 18'd0};
    vecs[1] = '{1'b1, 1'b0, 32'd1024, 32'h0,        32'hDEADBEEF, 18'd0};
    vecs[2] = '{1'b0, 1'b1, 32'd1028, 32'h12345678, 32'hDEADBEEF, 18'd2};
    vecs[3] = '{1'b1, 1'b0, 32'd1028, 32'h0,        32'h12345678, 18'd2};
    vecs[4] = '{1'b0, 1'b1, 32'd5024, 32'hA5A50F0F, 32'h12345678, 18'd2000};
    vecs[5] = '{1'b1, 1'b0, 32'd5024, 32'h0,        32'hA5A50F0F, 18'd2000};
    vecs[6] = '{1'b1, 1'b1, 32'd1032, 32'hCAFEF00D, 32'hA5A50F0F, 18'd4};
    vecs[7] = '{1'b1, 1'b0, 32'd1032, 32'h0,        32'hCAFEF00D, 18'd4};

    rst = 1'b0; sel = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
    address = '0; write_data = '0;
    repeat (2) @(negedge clk);
    #1;
    check("reset read_data", rd6, 32'h0);
    check("reset WE_N", 32'(we6), 32'd1);
    check("reset OE_N", 32'(oe6), 32'd1);
    check("reset SRAM_ADDR", 32'(a6), 32'd0);
    check("reset ready", 32'(rdy6), 32'd1);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i], 5, $sformatf("vec%0d", i));
      idle();
    end
    check("sram[0] kept", 32'(mem6[0]), 32'h0000BEEF);
    check("sram[1] kept", 32'(mem6[1]), 32'h0000DEAD);

    // Back-to-back: read held through DONE, write presented the very next cycle.
    s0 = starts6;
    run_vec('{1'b1, 1'b0, 32'd1028, 32'h0, 32'h12345678, 18'd2}, 5, "b2b read");
    run_vec('{1'b0, 1'b1, 32'd1036, 32'h0BADCAFE, 32'h12345678, 18'd6}, 5, "b2b write");
    idle();
    repeat (10) @(negedge clk);
    check("b2b access count", 32'(starts6 - s0), 32'd2);

    // Reset asserted during T1 of a write.
    @(negedge clk);
    wr_en = 1'b1; address = 32'd1040; write_data = 32'h11112222;
    @(negedge clk);
    #1;
    check("pre-reset WE_N at T1", 32'(we6), 32'd0);
    rst = 1'b0;
    #1;
    check("async reset WE_N", 32'(we6), 32'd1);
    check("async reset OE_N", 32'(oe6), 32'd1);
    check("async reset SRAM_ADDR", 32'(a6), 32'd0);
    check("async reset read_data", rd6, 32'h0);
    wr_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("post-reset ready", 32'(rdy6), 32'd1);
    check("post-reset WE_N", 32'(we6), 32'd1);

    // Four-cycle build: same data behaviour, ready at T3.
    sel = 1'b1;
    run_vec('{1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 32'h0, 18'd0}, 3, "ac4 write0");
    idle();
    run_vec('{1'b1, 1'b0, 32'd1024, 32'h0, 32'hDEADBEEF, 18'd0}, 3, "ac4 read0");
    idle();
    run_vec('{1'b0, 1'b1, 32'd1028, 32'h12345678, 32'hDEADBEEF, 18'd2}, 3, "ac4 write1");
    idle();
    run_vec('{1'b1, 1'b0, 32'd1028, 32'h0, 32'h12345678, 18'd2}, 3, "ac4 read1");
    idle();
    sel = 1'b0;

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
